// File: rtl/mod_mult.sv
// 256-bit modular multiplier, (a*b) mod p, MSB-first interleaved shift-add.
// One bit of b per RUN cycle; each cycle chains a doubling step and a
// conditional add, each followed by a single conditional subtract of p.
// Optional build macro MOD_MULT_SKIP_ZEROS_EN: start the bit walk at the
// most significant set bit of b instead of bit 255 (same result, shorter run).

package mod_mult_pkg;
  typedef struct packed {
    logic [255:0] p;
  } curve_parameters_t;
endpackage

// One modular addition step: r = (x + y) mod p, valid when x, y < p.
module mod_mult_add (
  input  logic [255:0] x,
  input  logic [255:0] y,
  input  logic [255:0] p,
  output logic [255:0] r
);
  logic [256:0] sum;
  logic         ge;

  // 257-bit sum keeps the carry; a single subtract of p is enough since sum < 2p
  always_comb begin
    sum = {1'b0, x} + {1'b0, y};
    ge  = (sum >= {1'b0, p});
    r   = ge ? (sum[255:0] - p) : sum[255:0];
  end
endmodule

module mod_mult
  import mod_mult_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [255:0]      a,
  input  logic [255:0]      b,
  input  curve_parameters_t params,
  output logic [255:0]      product,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t       state_q, state_d;
  logic [255:0] a_reg, b_reg, p_reg, acc;
  logic [7:0]   idx;
  logic [7:0]   start_idx;
  logic [255:0] dbl, addend, acc_nxt;

`ifdef MOD_MULT_SKIP_ZEROS_EN
  // Position of the highest set bit; b == 0 maps to 0, giving one no-op cycle
  function automatic logic [7:0] msb_pos(input logic [255:0] v);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 256; i++)
      if (v[i]) r = i[7:0];
    return r;
  endfunction

  assign start_idx = msb_pos(b);
`else
  assign start_idx = 8'd255;
`endif

  // Datapath: acc' = ((2*acc mod p) + (b[i] ? a : 0)) mod p
  assign addend = b_reg[idx] ? a_reg : '0;

  mod_mult_add u_dbl (.x(acc), .y(acc),    .p(p_reg), .r(dbl));
  mod_mult_add u_add (.x(dbl), .y(addend), .p(p_reg), .r(acc_nxt));

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; start only matters in IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (idx == 8'd0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand capture, iteration and result register
  always_ff @(posedge clk) begin
    if (reset) begin
      a_reg   <= '0;
      b_reg   <= '0;
      p_reg   <= '0;
      acc     <= '0;
      idx     <= 8'd255;
      product <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_reg <= a;
            b_reg <= b;
            p_reg <= params.p;
            acc   <= '0;
            idx   <= start_idx;
          end
        end
        RUN: begin
          acc <= acc_nxt;
          if (idx == 8'd0) product <= acc_nxt;
          else             idx     <= idx - 8'd1;
        end
        default: ;
      endcase
    end
  end

  // Status outputs decoded from the registered state
  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_mod_mult.sv
// Scoreboard bench for mod_mult: driver pushes (a*b) mod p and expected
// latency per accepted start; a negedge monitor pops on every done.
module tb_mod_mult;
  import mod_mult_pkg::*;

  localparam logic [255:0] P =
    256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;

  typedef struct {
    logic [255:0] prod;
    int           lat;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [255:0]      a, b;
  curve_parameters_t params;
  logic [255:0]      product;
  logic              busy, done;

  exp_t sbq[$];
  int   checks = 0;
  int   passed = 0;

  mod_mult dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
    .params(params), .product(product), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  function automatic logic [255:0] ref_mod(input logic [255:0] x, y, p);
    logic [511:0] t, r;
    t = {256'd0, x} * {256'd0, y};
    r = t % {256'd0, p};
    return r[255:0];
  endfunction

  function automatic int ref_lat(input logic [255:0] y);
`ifdef MOD_MULT_SKIP_ZEROS_EN
    int m;
    m = 0;
    for (int i = 255; i >= 0; i--)
      if (y[i]) begin m = i; break; end
    return m + 1;
`else
    return (y == y) ? 256 : 256;
`endif
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic chk_i(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 400) begin @(posedge clk); #1; n++; end
    if (busy) begin checks++; $display("FAIL idle_timeout: busy=%0d expected 0", busy); end
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 400) begin @(posedge clk); #1; n++; end
    if (!done) begin checks++; $display("FAIL done_timeout: done=%0d expected 1", done); end
  endtask

  // Present one operation, record its expectation, then scramble the inputs
  task automatic issue(input logic [255:0] x, y, p);
    exp_t e;
    wait_idle();
    a = x; b = y; params.p = p; start = 1'b1;
    e.prod = ref_mod(x, y, p);
    e.lat  = ref_lat(y);
    sbq.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
    a = rnd256(); b = rnd256(); params.p = rnd256();
  endtask

  task automatic run_op(input logic [255:0] x, y, p);
    issue(x, y, p);
    wait_done();
  endtask

  // Monitor: negedge sampling; reset seen at the previous negedge is what
  // the intervening posedge acted on
  initial begin
    int           cyc = 0, acc_cyc = 0, hold_err = 0;
    bit           prev_busy = 0, prev_done = 0, prev_rst = 1;
    logic [255:0] last_p = '0;
    exp_t         e;
    forever begin
      @(negedge clk);
      cyc++;
      if (prev_rst) begin
        last_p = product;
      end else begin
        if (busy && !prev_busy) acc_cyc = cyc;
        if (done) begin
          chk_i("done_single_pulse", int'(prev_done), 0);
          if (sbq.size() == 0) begin
            checks++;
            $display("FAIL unexpected_done: product %h with no pending op", product);
          end else begin
            e = sbq.pop_front();
            chk("product", product, e.prod);
            chk_i("latency", cyc - acc_cyc, e.lat);
            chk_i("product_hold", hold_err, 0);
          end
          hold_err = 0;
          last_p = product;
        end else if (product !== last_p) begin
          hold_err++;
        end
      end
      prev_busy = busy; prev_done = done; prev_rst = reset;
    end
  end

  initial begin
    #(980000);
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] x, y, p;
    reset = 1'b1; start = 1'b0; a = '0; b = '0; params.p = P;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_product", product, '0);
    chk_i("reset_busy", int'(busy), 0);
    chk_i("reset_done", int'(done), 0);
    reset = 1'b0;

    // Directed values
    run_op(256'd3, 256'd5, P);
    chk("a3_b5", product, 256'd15);
    run_op(P - 1, P - 1, P);
    chk("pm1_sq", product, 256'd1);
    run_op(P - 1, 256'd2, P);
    chk("pm1_x2", product, P - 2);
    run_op(256'd12345, 256'd0, P);
    chk("b_zero", product, '0);
    run_op(256'd12345, 256'd1, P);
    chk("b_one", product, 256'd12345);

    // start re-pulsed mid-run with other operands is ignored
    x = rnd256() >> 2; y = rnd256(); y[255] = 1'b1;
    issue(x, y, P);
    repeat (9) @(posedge clk);
    #1;
    a = rnd256() >> 2; b = rnd256(); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (189) @(posedge clk);
    #1;
    a = 256'd99; b = 256'd77; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    wait_done();
    chk("repulse_result", product, ref_mod(x, y, P));

    // Reset mid-run aborts without a done
    x = rnd256() >> 2; y = rnd256(); y[255] = 1'b1;
    issue(x, y, P);
    repeat (99) @(posedge clk);
    #1;
    sbq.delete();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk_i("abort_busy", int'(busy), 0);
    chk_i("abort_done", int'(done), 0);
    chk("abort_product", product, '0);
    run_op(256'd7, 256'd6, P);
    chk("after_abort", product, 256'd42);

    // Reset dominates start in the same cycle
    @(posedge clk); #1;
    reset = 1'b1; start = 1'b1; a = 256'd5; b = 256'd5;
    @(posedge clk); #1;
    chk_i("reset_over_start", int'(busy), 0);
    reset = 1'b0; start = 1'b0;

    // Random regression, back-to-back starts
    for (int k = 0; k < 250; k++) begin
      if (k[0]) p = P;
      else begin p = rnd256(); p[255] = 1'b1; p[0] = 1'b1; end
      x = rnd256();
      if (x >= p) x = x - p;
      y = rnd256() >> $urandom_range(0, 255);
      run_op(x, y, p);
    end

    repeat (5) @(posedge clk);
    #1;
    chk_i("scoreboard_empty", sbq.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
